result_broadcast_arbiter: RTL
=============================

// Module: result_broadcast_arbiter
// PURPOSE
//   Sits directly downstream of the ACU array. Captures each slot's sal_t result
//   when that slot completes, holds it, and broadcasts one result per cycle onto
//   the common data bus (CDB) using round-robin arbitration with back-pressure.
//   Returns per-slot busy flags to the reservation station so that a slot is not
//   re-issued while its result is still waiting.
// PARAMETERS
//   size    15   number of ACU slots / result holding registers
//   PTR_W   $clog2(size)   width of the round-robin pointer and grant index
// PORTS
//   clk          in   1          rising-edge clock
//   rst          in   1          asynchronous, active-low reset
//   res_in       in   sal_t[size] per-slot ACU result (the ACU out array)
//   res_valid    in   size       res_valid[i]=1: res_in[i] is a completed result this cycle
//   flush        in   1          synchronous squash of all held results (mispredict)
//   cdb_ready    in   1          downstream accepts the broadcast this cycle
//   cdb_valid    out  1          a held result is on cdb_out
//   cdb_out      out  sal_t      broadcast result
//   cdb_slot     out  PTR_W      slot index of cdb_out
//   slot_busy    out  size       slot_busy[i]=1: slot i holds an unbroadcast result
//   pending_cnt  out  PTR_W+1    number of held results
// BEHAVIOUR
//   State:
//     - hold[i] (sal_t) and hold_v[i] per slot.
//     - rr_ptr (PTR_W), the next index of highest priority.
//   Reset (rst=0, async):
//     - hold_v all 0, rr_ptr=0, hold[] cleared to 0.
//     - Hence cdb_valid=0, cdb_slot=0, cdb_out=0, slot_busy=0, pending_cnt=0.
//   Grant (combinational):
//     - g = first i with hold_v[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo size.
//     - cdb_valid = |hold_v; cdb_out = hold[g]; cdb_slot = g.
//     - When cdb_valid=0: cdb_out=0 and cdb_slot=0.
//   Handshake:
//     - Transfer when cdb_valid && cdb_ready.
//     - On transfer, at the clock edge: hold_v[g] <= 0; rr_ptr <= (g==size-1) ? 0 : g+1.
//     - No transfer: rr_ptr and the grant are unchanged.
//     - cdb_out/cdb_slot stay stable until taken (a new capture in a lower-priority
//       slot never preempts g; a capture ahead of g in RR order may change g only
//       while cdb_ready=0).
//   Capture (edge):
//     - res_valid[i] && !hold_v[i] -> hold[i] <= res_in[i], hold_v[i] <= 1.
//     - Same-cycle transfer of slot i and res_valid[i]=1 -> new result captured,
//       hold_v[i] stays 1.
//     - res_valid[i] while hold_v[i]=1 and not transferring is an RS protocol
//       violation: the held value is kept, the new one dropped, and a simulation
//       assertion fires.
//   Latency: res_valid at edge N -> cdb_valid from cycle N+1 at the earliest.
//     No same-cycle bypass.
//   slot_busy[i] = hold_v[i] && !(transfer && g==i). This is combinational, so
//     the RS may issue into slot i in the cycle its result leaves.
//   pending_cnt = popcount(hold_v). Maximum value is size.
//   flush:
//     - Clears all hold_v at the edge.
//     - Overrides both capture and transfer that cycle; rr_ptr is unchanged.
//     - cdb_valid may be 1 in the flush cycle; downstream must discard it.
//   Wrap: the RR scan and rr_ptr wrap from size-1 to 0.
//     With size not a power of two, rr_ptr never exceeds size-1.
//   Fairness: a held slot is broadcast within size transfers.
// TESTING
//   1. Reset mid-operation with 3 slots held, rst=0 -> all outputs 0 immediately;
//      after release with cdb_ready=1 and no res_valid -> cdb_valid stays 0.
//   2. res_valid[4] with res_in[4]=R, cdb_ready=1 -> next cycle cdb_valid=1,
//      cdb_slot=4, cdb_out=R; one cycle later cdb_valid=0, rr_ptr=5.
//   3. Slots 0, 7, 14 valid together, rr_ptr=8 -> broadcast order 14, 0, 7;
//      pending_cnt 3, 2, 1, 0.
//   4. cdb_ready=0 for 5 cycles with slot 2 held -> cdb_out stable,
//      slot_busy[2]=1 throughout; cdb_ready=1 -> one transfer, slot_busy[2]
//      drops in the same cycle.
//   5. Slot 3 transferring while res_valid[3]=1 with new value S -> next cycle
//      hold_v[3]=1 and cdb_out=S.
//   6. All 15 slots valid, then flush asserted together with res_valid[1] ->
//      next cycle pending_cnt=0, cdb_valid=0, rr_ptr unchanged.

Source files
------------

// File: rtl/result_broadcast_arbiter_if.sv
// Result/CDB bundle between the ACU array, reservation station and the broadcast arbiter.
// master = arbiter side, slave = environment (ACU/RS/CDB consumer).
interface result_broadcast_arbiter_if #(
    parameter int size   = 15,
    parameter int DATA_W = 32
);
    localparam int PTR_W = $clog2(size);

    logic [size-1:0][DATA_W-1:0] res_in;
    logic [size-1:0]             res_valid;
    logic                        flush;
    logic                        cdb_ready;
    logic                        cdb_valid;
    logic [DATA_W-1:0]           cdb_out;
    logic [PTR_W-1:0]            cdb_slot;
    logic [size-1:0]             slot_busy;
    logic [PTR_W:0]              pending_cnt;

    modport master (
        input  res_in, res_valid, flush, cdb_ready,
        output cdb_valid, cdb_out, cdb_slot, slot_busy, pending_cnt
    );

    modport slave (
        output res_in, res_valid, flush, cdb_ready,
        input  cdb_valid, cdb_out, cdb_slot, slot_busy, pending_cnt
    );
endinterface

// File: rtl/result_broadcast_arbiter.sv
// Holds completed ACU results per slot and broadcasts one per cycle onto the CDB,
// round-robin with back-pressure; reports per-slot busy flags back to the RS.
module result_broadcast_arbiter #(
    parameter int size   = 15,
    parameter int DATA_W = 32,
    parameter int PTR_W  = $clog2(size)
) (
    input  logic                      clk,
    input  logic                      rst,
    result_broadcast_arbiter_if.master bus
);
    typedef logic [DATA_W-1:0] sal_t;

    sal_t              hold_q [size];
    sal_t              hold_d [size];
    logic [size-1:0]   hold_v_q, hold_v_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;

    logic [PTR_W-1:0]  grant;
    logic              found;
    logic [PTR_W:0]    scan_idx;
    logic              any_v;
    logic              xfer;
    logic [size-1:0]   busy;
    logic [PTR_W:0]    cnt;
    logic [size-1:0]   viol;

    // Round-robin scan starting at rr_ptr; the sum never exceeds 2*(size-1) so one subtract wraps it.
    always_comb begin
        grant    = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < size; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (scan_idx >= (PTR_W+1)'(size)) begin
                scan_idx = scan_idx - (PTR_W+1)'(size);
            end
            if (!found && hold_v_q[scan_idx[PTR_W-1:0]]) begin
                found = 1'b1;
                grant = scan_idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        any_v = |hold_v_q;
        xfer  = any_v && bus.cdb_ready;
        cnt   = '0;
        busy  = '0;
        for (int i = 0; i < size; i++) begin
            busy[i] = hold_v_q[i] && !(xfer && (grant == PTR_W'(i)));
            cnt     = cnt + (PTR_W+1)'(hold_v_q[i]);
        end
        viol = bus.res_valid & busy & {size{!bus.flush}};
    end

    assign bus.cdb_valid   = any_v;
    assign bus.cdb_out     = any_v ? hold_q[grant] : '0;
    assign bus.cdb_slot    = grant;
    assign bus.slot_busy   = busy;
    assign bus.pending_cnt = cnt;

    // Clearing the granted slot before the capture test lets a same-cycle re-issue land.
    always_comb begin
        hold_v_d = hold_v_q;
        rr_ptr_d = rr_ptr_q;
        for (int i = 0; i < size; i++) begin
            hold_d[i] = hold_q[i];
        end
        if (xfer) begin
            hold_v_d[grant] = 1'b0;
            rr_ptr_d        = (grant == PTR_W'(size-1)) ? '0 : grant + PTR_W'(1);
        end
        for (int i = 0; i < size; i++) begin
            if (bus.res_valid[i] && !hold_v_d[i]) begin
                hold_d[i]   = bus.res_in[i];
                hold_v_d[i] = 1'b1;
            end
        end
        if (bus.flush) begin
            hold_v_d = '0;
            rr_ptr_d = rr_ptr_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_v_q <= '0;
            rr_ptr_q <= '0;
            for (int i = 0; i < size; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            hold_v_q <= hold_v_d;
            rr_ptr_q <= rr_ptr_d;
            for (int i = 0; i < size; i++) begin
                hold_q[i] <= hold_d[i];
            end
        end
    end

    // The RS must never complete into a slot whose previous result is still waiting.
    rs_protocol_chk: assert property (@(posedge clk) disable iff (!rst) viol == '0);

endmodule
